// File: rtl/nonce_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nonce_sched_pkg
// Description : Shared types and constants for the nonce sweep scheduler.
//               State and status encodings, the nonce width and the range
//               helper used by the scheduler and its hit detector.
// Revision    : 1.0 - initial release
// ============================================================================
package nonce_sched_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_DRAIN  = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_FOUND     = 2'd0,
    ST_EXHAUSTED = 2'd1,
    ST_TIMEOUT   = 2'd2,
    ST_ABORTED   = 2'd3
  } status_e;

  // Nonces are carried one bit wider than NONCE_W so that a batch running
  // past 0xFFFFFFFF compares as out of range instead of wrapping to 0.
  function automatic logic nonce_in_range(input logic [NONCE_W:0]   nonce,
                                          input logic [NONCE_W-1:0] last);
    return (nonce <= {1'b0, last});
  endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_hit_detect.sv
`default_nettype none
// ============================================================================
// Module      : nonce_hit_detect
// Description : Qualifies each incoming result (nonce within range and H0
//               below target) and captures the first qualifying nonce of
//               the current batch.
// Ports       : clk, reset_n   - clock, async active-low reset
//               clear_i        - start of batch, drops the hit flag
//               sample_i       - a result word is present and may be taken
//               base_i/idx_i   - batch base nonce and result index
//               h0_i           - first digest word of the result
//               last_i         - last nonce of the sweep (inclusive)
//               target_i       - difficulty target (hit if h0 < target)
//               hit_o          - a hit has been captured in this batch
//               found_nonce_o  - nonce of the captured hit
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_hit_detect
  import nonce_sched_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               sample_i,
  input  logic [NONCE_W-1:0] base_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [NONCE_W-1:0] h0_i,
  input  logic [NONCE_W-1:0] last_i,
  input  logic [NONCE_W-1:0] target_i,
  output logic               hit_o,
  output logic [NONCE_W-1:0] found_nonce_o
);

  logic [NONCE_W:0]   w_nonce_ext;
  logic               w_hit_now;
  logic               hit_q;
  logic [NONCE_W-1:0] found_q;

  assign w_nonce_ext = {1'b0, base_i} + {{(NONCE_W + 1 - IDX_W){1'b0}}, idx_i};

  // Results arrive in index order, so refusing further hits once the flag
  // is set keeps the lowest-index hit of the batch.
  assign w_hit_now = sample_i && !hit_q
                  && nonce_in_range(w_nonce_ext, last_i)
                  && (h0_i < target_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q   <= 1'b0;
      found_q <= '0;
    end else if (clear_i) begin
      hit_q   <= 1'b0;
    end else if (w_hit_now) begin
      hit_q   <= 1'b1;
      found_q <= w_nonce_ext[NONCE_W-1:0];
    end
  end

  assign hit_o         = hit_q;
  assign found_nonce_o = found_q;

endmodule
`default_nettype wire

// File: rtl/nonce_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nonce_sweep_scheduler
// Description : Drives a multi-nonce SHA-256d engine through consecutive
//               batches of NONCES nonces, checks each result against the
//               target and stops on hit, range exhaustion, abort or engine
//               timeout.
// Ports       : clk, reset_n             - clock, async active-low reset
//               start, abort             - host sweep control
//               nonce_first/nonce_last   - inclusive nonce range
//               target                   - hit if res_h0 < target
//               eng_start/eng_nonce_base - batch launch to the engine
//               eng_done, res_*          - engine completion and results
//               busy, done, status       - sweep progress and outcome
//               found_nonce, batch_count - winning nonce, batches launched
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_sweep_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int NONCES         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NONCE_W-1:0]        nonce_first,
  input  logic [NONCE_W-1:0]        nonce_last,
  input  logic [NONCE_W-1:0]        target,
  output logic                      eng_start,
  output logic [NONCE_W-1:0]        eng_nonce_base,
  input  logic                      eng_done,
  input  logic                      res_valid,
  input  logic [$clog2(NONCES)-1:0] res_idx,
  input  logic [NONCE_W-1:0]        res_h0,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                status,
  output logic [NONCE_W-1:0]        found_nonce,
  output logic [31:0]               batch_count
);

  localparam int                 c_IDX_W    = $clog2(NONCES);
  localparam int                 c_WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_WD_W-1:0]  c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_WD_W-1:0]  c_WD_ONE   = c_WD_W'(1);
  localparam logic [NONCE_W-1:0] c_STRIDE   = NONCE_W'(NONCES);
  localparam logic [NONCE_W:0]   c_STRIDE_X = (NONCE_W + 1)'(NONCES);

  state_e             state_q,  state_d;
  status_e            status_q, status_d;
  logic [NONCE_W-1:0] base_q,   base_d;
  logic [NONCE_W-1:0] last_q,   last_d;
  logic [NONCE_W-1:0] target_q, target_d;
  logic [31:0]        batch_q,  batch_d;
  logic               busy_q,   busy_d;
  logic [c_WD_W-1:0]  wd_q,     wd_d;

  logic [c_WD_W-1:0]  w_wd_inc;
  logic               w_wd_expired;
  logic [NONCE_W:0]   w_next_base_ext;
  logic               w_hit;
  logic               w_hit_clear;
  logic               w_hit_sample;

  // The watchdog is cleared in LAUNCH and counts WAIT/DRAIN cycles. Expiry
  // is judged on the incremented value so that the FINISH cycle (and its
  // done pulse) lands exactly TIMEOUT_CYCLES cycles after eng_start.
  assign w_wd_inc        = wd_q + c_WD_ONE;
  assign w_wd_expired    = (w_wd_inc == c_WD_LIMIT);
  assign w_next_base_ext = {1'b0, base_q} + c_STRIDE_X;

  assign w_hit_clear  = (state_q == S_LAUNCH);
  assign w_hit_sample = (state_q == S_WAIT) && res_valid;

  nonce_hit_detect #(
    .IDX_W (c_IDX_W)
  ) u_hit_detect (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear_i       (w_hit_clear),
    .sample_i      (w_hit_sample),
    .base_i        (base_q),
    .idx_i         (res_idx),
    .h0_i          (res_h0),
    .last_i        (last_q),
    .target_i      (target_q),
    .hit_o         (w_hit),
    .found_nonce_o (found_nonce)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      status_q <= ST_FOUND;
      base_q   <= '0;
      last_q   <= '0;
      target_q <= '0;
      batch_q  <= '0;
      busy_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      base_q   <= base_d;
      last_q   <= last_d;
      target_q <= target_d;
      batch_q  <= batch_d;
      busy_q   <= busy_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    base_d    = base_q;
    last_d    = last_q;
    target_d  = target_q;
    batch_d   = batch_q;
    busy_d    = busy_q;
    wd_d      = wd_q;
    eng_start = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = nonce_first;
          last_d   = nonce_last;
          target_d = target;
          batch_d  = '0;
          busy_d   = 1'b1;
          status_d = ST_FOUND;
          if (nonce_first > nonce_last) begin
            status_d = ST_EXHAUSTED;
            state_d  = S_FINISH;
          end else begin
            state_d  = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        eng_start = 1'b1;
        batch_d   = batch_q + 32'd1;
        wd_d      = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        wd_d = w_wd_inc;
        // eng_done wins over a coincident abort; CHECK decides whether the
        // abort still matters once the batch hit flag is known.
        if (eng_done) begin
          state_d = S_CHECK;
        end else if (w_wd_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = S_FINISH;
        end else if (abort) begin
          state_d = S_DRAIN;
        end
      end

      S_CHECK: begin
        if (w_hit) begin
          status_d = ST_FOUND;
          state_d  = S_FINISH;
        end else if (abort) begin
          status_d = ST_ABORTED;
          state_d  = S_FINISH;
        end else if (!nonce_in_range(w_next_base_ext, last_q)) begin
          // Also catches the next base wrapping past 0xFFFFFFFF.
          status_d = ST_EXHAUSTED;
          state_d  = S_FINISH;
        end else begin
          base_d  = base_q + c_STRIDE;
          state_d = S_LAUNCH;
        end
      end

      S_DRAIN: begin
        // Results are ignored; an engine that never finishes still ends the
        // sweep, but the outcome remains an abort.
        wd_d = w_wd_inc;
        if (eng_done || w_wd_expired) begin
          status_d = ST_ABORTED;
          state_d  = S_FINISH;
        end
      end

      S_FINISH: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign eng_nonce_base = base_q;
  assign busy           = busy_q;
  assign status         = status_q;
  assign batch_count    = batch_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_sweep_scheduler
// Description : Self-checking bench for nonce_sweep_scheduler. An engine
//               model answers each batch from a nonce->H0 table; a reference
//               model walks the nonce range batch by batch to predict the
//               outcome, found nonce and launch bases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_sweep_scheduler;

  localparam int NONCES         = 16;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int IDX_W          = $clog2(NONCES);
  localparam int BUDGET         = 3000;

  localparam logic [1:0] ST_FOUND = 2'd0;
  localparam logic [1:0] ST_EXH   = 2'd1;
  localparam logic [1:0] ST_TMO   = 2'd2;
  localparam logic [1:0] ST_ABT   = 2'd3;

  logic             clk = 1'b0;
  logic             reset_n, start, abort;
  logic [31:0]      nonce_first, nonce_last, target;
  logic             eng_start;
  logic [31:0]      eng_nonce_base;
  logic             eng_done, res_valid;
  logic [IDX_W-1:0] res_idx;
  logic [31:0]      res_h0;
  logic             busy, done;
  logic [1:0]       status;
  logic [31:0]      found_nonce, batch_count;

  nonce_sweep_scheduler #(
    .NONCES         (NONCES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .nonce_first    (nonce_first),
    .nonce_last     (nonce_last),
    .target         (target),
    .eng_start      (eng_start),
    .eng_nonce_base (eng_nonce_base),
    .eng_done       (eng_done),
    .res_valid      (res_valid),
    .res_idx        (res_idx),
    .res_h0         (res_h0),
    .busy           (busy),
    .done           (done),
    .status         (status),
    .found_nonce    (found_nonce),
    .batch_count    (batch_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Engine / monitor bookkeeping
  logic [31:0] h0_map [logic [31:0]];
  bit          eng_hang = 1'b0;
  int          eng_lat  = 0;
  int          n_starts, first_start_cyc, last_done_cyc, start_cyc, done_cyc;
  bit          gap_armed;
  logic [31:0] cur_base;
  logic [31:0] start_bases[$];

  // Reference model results
  logic [1:0]  exp_st;
  logic [31:0] exp_found;
  int          exp_nb;
  logic [31:0] exp_bases[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] h0_of(input logic [31:0] n);
    return h0_map.exists(n) ? h0_map[n] : 32'hFFFF_FFFF;
  endfunction

  // Walk the range in NONCES-sized batches; the first in-range nonce with
  // H0 below target wins, otherwise the sweep ends once the next batch
  // would start beyond the last nonce.
  task automatic model(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t);
    longint b, hi, lim;
    exp_bases.delete();
    exp_nb    = 0;
    exp_found = 32'd0;
    exp_st    = ST_EXH;
    lim       = longint'(l);
    if (f > l) return;
    b = longint'(f);
    forever begin
      exp_nb++;
      exp_bases.push_back(b[31:0]);
      hi = b + NONCES - 1;
      if (hi > lim) hi = lim;
      for (longint n = b; n <= hi; n++) begin
        if (h0_of(n[31:0]) < t) begin
          exp_st    = ST_FOUND;
          exp_found = n[31:0];
          return;
        end
      end
      if (b + NONCES > lim) return;
      b += NONCES;
    end
  endtask

  task automatic clear_mon();
    gap_armed       = 1'b0;
    n_starts        = 0;
    first_start_cyc = -1;
    last_done_cyc   = -1;
    start_bases.delete();
  endtask

  // Engine model: answers each eng_start with NONCES in-order results
  // (random gaps) followed by an eng_done pulse.
  initial begin : engine
    logic [31:0] b;
    eng_done  = 1'b0;
    res_valid = 1'b0;
    res_idx   = '0;
    res_h0    = 32'd0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && eng_start === 1'b1 && !eng_hang) begin
        b = eng_nonce_base;
        @(negedge clk);
        repeat (eng_lat) @(negedge clk);
        for (int i = 0; i < NONCES; i++) begin
          if (reset_n !== 1'b1) break;
          res_valid = 1'b1;
          res_idx   = IDX_W'(i);
          res_h0    = h0_of(b + 32'(i));
          @(negedge clk);
          res_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        if (reset_n === 1'b1) begin
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
        end
      end
    end
  end

  initial begin : mon_neg
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && eng_start === 1'b1) begin
        if (gap_armed) chk("launch_gap", 64'(cyc - last_done_cyc), 64'd2);
        n_starts++;
        start_bases.push_back(eng_nonce_base);
        if (first_start_cyc < 0) first_start_cyc = cyc;
        cur_base = eng_nonce_base;
      end
    end
  end

  initial begin : mon_pos
    forever begin
      @(posedge clk);
      if (reset_n === 1'b1 && eng_done === 1'b1) begin
        last_done_cyc = cyc;
        gap_armed     = 1'b1;
      end
      if (reset_n === 1'b1 && res_valid === 1'b1)
        chk("base_stable", eng_nonce_base, cur_base);
    end
  end

  task automatic do_sweep(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t,
                          input int abort_delay, input bit restart);
    int w;
    bit timed_out;
    clear_mon();
    @(negedge clk);
    nonce_first = f;
    nonce_last  = l;
    target      = t;
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start       = 1'b0;
    // Range inputs are only sampled on the accepted start.
    nonce_first = $urandom;
    nonce_last  = $urandom;
    target      = $urandom;
    chk("busy_after_start", busy, 1);
    w = 0;
    timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (w >= BUDGET) begin
        timed_out = 1'b1;
        break;
      end
      if (w == abort_delay) abort = 1'b1;
      start = (restart && w == 3);
      @(negedge clk);
      w++;
    end
    start    = 1'b0;
    done_cyc = cyc;
    chk("done_within_budget", timed_out, 0);
    chk("busy_at_done", busy, 1);
    abort = 1'b0;
  endtask

  task automatic run_sweep(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t,
                           input bit restart);
    model(f, l, t);
    do_sweep(f, l, t, -1, restart);
    chk("status", status, exp_st);
    chk("batch_count", batch_count, exp_nb);
    chk("eng_start_count", n_starts, exp_nb);
    if (exp_st == ST_FOUND) chk("found_nonce", found_nonce, exp_found);
    for (int i = 0; i < exp_bases.size() && i < start_bases.size(); i++)
      chk("batch_base", start_bases[i], exp_bases[i]);
    if (exp_nb > 0) begin
      chk("first_launch_latency", 64'(first_start_cyc - start_cyc), 64'd1);
      chk("done_latency", 64'(done_cyc - last_done_cyc), 64'd2);
    end else begin
      chk("empty_range_latency", 64'(done_cyc - start_cyc), 64'd1);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("status_held", status, exp_st);
    h0_map.delete();
  endtask

  initial begin : main
    logic [31:0] f, l, t, n;
    longint      ll;
    int          len;

    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    nonce_first = 32'd0;
    nonce_last  = 32'd0;
    target      = 32'd0;
    clear_mon();
    cur_base    = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_status", status, 0);
    chk("rst_found", found_nonce, 0);
    chk("rst_batch_count", batch_count, 0);
    chk("rst_base", eng_nonce_base, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Hit in first batch
    h0_map[32'd5] = 32'h0000_0FFF;
    run_sweep(32'd0, 32'd1023, 32'h0000_1000, 1'b0);

    // Two hits in third batch plus an H0 equal to target (not a hit)
    h0_map[32'd20] = 32'h0000_1000;
    h0_map[32'd35] = 32'h0000_0010;
    h0_map[32'd41] = 32'h0000_0000;
    run_sweep(32'd0, 32'd1023, 32'h0000_1000, 1'b0);

    // Partial final batch: the only low H0 lies past the last nonce
    h0_map[32'd23] = 32'h0000_0000;
    run_sweep(32'd0, 32'd20, 32'h0000_1000, 1'b0);

    // Top of the nonce space, exact batch
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_1000, 1'b0);

    // Batch straddling 2^32: wrapped nonce 2 must not count
    h0_map[32'd2] = 32'h0000_0000;
    run_sweep(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h0000_1000, 1'b0);

    // Empty range
    run_sweep(32'd5, 32'd4, 32'h0000_1000, 1'b0);

    // Randomized sweeps, half with a start pulse while busy
    for (int k = 0; k < 10; k++) begin
      eng_lat = $urandom_range(0, 3);
      f   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 40))) : $urandom;
      len = $urandom_range(0, 90);
      ll  = longint'(f) + len;
      l   = (ll > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : ll[31:0];
      if ($urandom_range(0, 7) == 0 && f != 32'd0) l = f - 32'd1;
      t   = 32'($urandom_range(1, 32'h0000_FFFF));
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        n = f + 32'($urandom_range(0, len + 8));
        h0_map[n] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, t - 1))
                                                : t + 32'($urandom_range(0, 3));
      end
      run_sweep(f, l, t, (k % 2) == 1);
    end
    eng_lat = 0;

    // Engine never finishes
    eng_hang = 1'b1;
    do_sweep(32'd100, 32'd5000, 32'h10, -1, 1'b0);
    chk("tmo_status", status, ST_TMO);
    chk("tmo_latency", 64'(done_cyc - first_start_cyc), 64'(TIMEOUT_CYCLES));
    chk("tmo_batch_count", batch_count, 1);
    chk("tmo_starts", n_starts, 1);
    eng_hang = 1'b0;
    @(negedge clk);

    // Abort mid-WAIT; a later in-range hit must not matter
    eng_lat = 8;
    h0_map[32'd1002] = 32'h0000_0000;
    do_sweep(32'd1000, 32'd5000, 32'h100, 4, 1'b0);
    chk("abt_status", status, ST_ABT);
    chk("abt_starts", n_starts, 1);
    chk("abt_batch_count", batch_count, 1);
    chk("abt_done_latency", 64'(done_cyc - last_done_cyc), 64'd1);
    eng_lat = 0;
    h0_map.delete();
    repeat (3) @(negedge clk);
    chk("abt_no_relaunch", n_starts, 1);

    // Abort while idle does nothing
    abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_start", eng_start, 0);
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_done", done, 0);

    // Asynchronous reset in the middle of a sweep
    clear_mon();
    eng_hang    = 1'b1;
    nonce_first = 32'd0;
    nonce_last  = 32'd500;
    target      = 32'h100;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_batches", batch_count, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_eng_start", eng_start, 0);
    chk("mid_rst_status", status, 0);
    chk("mid_rst_batch_count", batch_count, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    eng_hang = 1'b0;

    h0_map[32'd7] = 32'h0000_0001;
    run_sweep(32'd0, 32'd100, 32'h100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
